// File: rtl/demux_1_to_4_reg.sv
// Purpose : routes one input word to one of four lanes, each with a one-entry holding register.
// Latency : 1 cycle from accepted input to out_valid; pending is registered alongside the full flags.
// Backpr. : a full lane whose consumer is not ready stalls only inputs addressed to that lane.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-high reset (clears flags, data and pending)
//   in_data    - input word, LENGTH bits
//   sel        - destination lane 0..3
//   in_valid   - producer offers in_data/sel this cycle
//   in_ready   - block accepts the offered word this cycle (combinational, independent of in_valid)
//   out_0..3   - lane holding-register contents
//   out_valid  - bit i: lane i holds an undelivered word
//   out_ready  - bit i: consumer of lane i takes the word this cycle
//   pending    - number of full lanes (0..4), registered
module demux_1_to_4_reg #(
    parameter int LENGTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] in_data,
    input  logic [1:0]        sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LENGTH-1:0] out_0,
    output logic [LENGTH-1:0] out_1,
    output logic [LENGTH-1:0] out_2,
    output logic [LENGTH-1:0] out_3,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [2:0]        pending
);

    // Lane state
    logic [LENGTH-1:0] data_q [4];
    logic [LENGTH-1:0] data_d [4];
    logic [3:0]        full_q;
    logic [3:0]        full_d;
    logic [2:0]        pending_q;
    logic [2:0]        pending_d;

    // Per-lane transfer strobes
    logic              in_xfer;
    logic [3:0]        load;
    logic [3:0]        out_xfer;

    // The addressed lane can take a word if it is empty, or if its current word
    // leaves on this same edge (pass-through without a bubble).
    assign in_ready = ~full_q[sel] | out_ready[sel];
    assign in_xfer  = in_valid & in_ready;

    always_comb begin
        load      = '0;
        out_xfer  = '0;
        full_d    = full_q;
        pending_d = '0;
        for (int i = 0; i < 4; i++) begin
            data_d[i]   = data_q[i];
            load[i]     = in_xfer && (sel == 2'(i));
            out_xfer[i] = full_q[i] & out_ready[i];
            // A load wins over a drain on the same lane: the new word replaces the
            // delivered one and the lane stays full.
            if (load[i]) begin
                data_d[i] = in_data;
                full_d[i] = 1'b1;
            end else if (out_xfer[i]) begin
                full_d[i] = 1'b0;
            end
            // Count the post-edge occupancy so pending always matches out_valid.
            pending_d = pending_d + 3'(full_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            pending_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q    <= full_d;
            pending_q <= pending_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_0     = data_q[0];
    assign out_1     = data_q[1];
    assign out_2     = data_q[2];
    assign out_3     = data_q[3];
    assign out_valid = full_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_demux_1_to_4_reg.sv
// Purpose : directed and random checks for demux_1_to_4_reg with a per-lane scoreboard.
// Latency : inputs driven 1 ns after the rising edge; outputs sampled before the next edge.
// Backpr. : out_ready is driven directly by the bench, fixed or random per phase.
module tb_demux_1_to_4_reg;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_0, out_1, out_2, out_3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [2:0]  pending;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] outs [4];
    assign outs[0] = out_0;
    assign outs[1] = out_1;
    assign outs[2] = out_2;
    assign outs[3] = out_3;

    demux_1_to_4_reg #(.LENGTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] s, input logic [15:0] d);
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
    endtask

    // Scoreboard state for the random phase
    logic [15:0] q [4][$];
    logic [3:0]  mfull;
    logic        exp_rdy;
    logic [15:0] exp_word;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd1;
        in_data   = 16'hFFFF;
        out_ready = 4'b0000;

        // Reset, with a word offered that must be discarded
        step();
        step();
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_out_%0d", i), 32'(outs[i]), 32'h0);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
        end
        rst = 1'b0;

        // Basic routing to lane 2
        offer(2'd2, 16'hA5A5);
        step();
        in_valid = 1'b0;
        chk("route_out_valid", 32'(out_valid), 32'h4);
        chk("route_out_2", 32'(out_2), 32'hA5A5);
        chk("route_pending", 32'(pending), 32'h1);

        // Drain lane 2
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        chk("drain2_out_valid", 32'(out_valid), 32'h0);
        chk("drain2_pending", 32'(pending), 32'h0);

        // Backpressure on lane 1 only
        offer(2'd1, 16'h1234);
        step();
        offer(2'd1, 16'h1111);
        #1;
        chk("bp_in_ready_lane1", 32'(in_ready), 32'h0);
        step();
        chk("bp_out_1_held", 32'(out_1), 32'h1234);
        chk("bp_out_valid_held", 32'(out_valid), 32'h2);
        offer(2'd3, 16'h3333);
        #1;
        chk("bp_in_ready_lane3", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("bp_out_valid", 32'(out_valid), 32'hA);
        chk("bp_pending", 32'(pending), 32'h2);
        chk("bp_out_3", 32'(out_3), 32'h3333);
        chk("bp_out_1_final", 32'(out_1), 32'h1234);

        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        chk("drain_all_out_valid", 32'(out_valid), 32'h0);

        // Pass-through on lane 0: deliver and reload on the same edge
        offer(2'd0, 16'h0001);
        step();
        out_ready = 4'b0001;
        offer(2'd0, 16'h0002);
        #1;
        chk("pt_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("pt_out_0", 32'(out_0), 32'h0002);
        chk("pt_out_valid", 32'(out_valid), 32'h1);
        chk("pt_pending", 32'(pending), 32'h1);
        step();
        out_ready = 4'b0000;
        chk("pt_drain_out_valid", 32'(out_valid), 32'h0);

        // All lanes full
        for (int i = 0; i < 4; i++) begin
            offer(2'(i), 16'h0010 + 16'(i));
            step();
        end
        in_valid = 1'b0;
        chk("full_pending", 32'(pending), 32'h4);
        chk("full_out_valid", 32'(out_valid), 32'hF);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("full_in_ready_sel%0d", s), 32'(in_ready), 32'h0);
            chk($sformatf("full_out_%0d", s), 32'(outs[s]), 32'h0010 + 32'(s));
        end
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        chk("empty_pending", 32'(pending), 32'h0);
        chk("empty_out_valid", 32'(out_valid), 32'h0);

        // Mid-operation reset with a lane-1 offer on the reset edge
        offer(2'd0, 16'hAAAA);
        step();
        offer(2'd3, 16'hBBBB);
        step();
        chk("pre_rst_out_valid", 32'(out_valid), 32'h9);
        rst = 1'b1;
        offer(2'd1, 16'hCCCC);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_pending", 32'(pending), 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("mrst_out_%0d", i), 32'(outs[i]), 32'h0);
        step();
        chk("mrst_lane1_not_loaded", 32'(out_valid), 32'h0);

        // Random stream against a per-lane scoreboard
        mfull = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if (c < 590) begin
                in_valid  = 1'($urandom_range(0, 1));
                sel       = 2'($urandom_range(0, 3));
                in_data   = 16'($urandom);
                out_ready = 4'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 4'b1111;
            end
            #1;
            exp_rdy = ~mfull[sel] | out_ready[sel];
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int i = 0; i < 4; i++) begin
                if (mfull[i] && out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("rnd_lane%0d_spurious", i), 32'h1, 32'h0);
                    end else begin
                        exp_word = q[i].pop_front();
                        chk($sformatf("rnd_lane%0d_data", i), 32'(outs[i]), 32'(exp_word));
                    end
                    mfull[i] = 1'b0;
                end
            end
            if (in_valid && exp_rdy) begin
                q[sel].push_back(in_data);
                mfull[sel] = 1'b1;
            end
            step();
            chk("rnd_out_valid", 32'(out_valid), 32'(mfull));
            chk("rnd_pending", 32'(pending), 32'($countones(out_valid)));
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rnd_lane%0d_leftover", i), 32'(q[i].size()), 32'h0);
        chk("rnd_final_pending", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1_to_4_reg.md
DEMUX_1_TO_4_REG -- requirements
Module: demux_1_to_4_reg

Interface
REQ-001 The block SHALL provide parameter LENGTH, default 16, which sets the data width of the input and of each output lane.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL provide port in_data, input, LENGTH bits: the input word.
REQ-005 The block SHALL provide port sel, input, 2 bits: the destination lane (0..3) for in_data.
REQ-006 The block SHALL provide port in_valid, input, 1 bit: the producer offers in_data/sel this cycle.
REQ-007 The block SHALL provide port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-008 The block SHALL provide ports out_0..out_3, output, LENGTH bits each: the per-lane holding-register contents.
REQ-009 The block SHALL provide port out_valid, output, 4 bits: bit i set means lane i holds an undelivered word.
REQ-010 The block SHALL provide port out_ready, input, 4 bits: bit i set means the consumer of lane i takes the word this cycle.
REQ-011 The block SHALL provide port pending, output, 3 bits: the number of full lanes (0..4).

Function
REQ-012 Each lane SHALL have a one-entry holding register (data, full flag); out_i SHALL equal the lane i data register, and out_valid[i] SHALL equal the lane i full flag.
REQ-013 in_ready SHALL be combinational and equal (!full[sel]) OR out_ready[sel]; it SHALL NOT depend on in_valid.
REQ-014 An input transfer occurs when in_valid && in_ready; on that edge the lane sel data register SHALL load in_data and full[sel] SHALL become 1; latency from accepted input to out_valid SHALL be exactly 1 cycle.
REQ-015 An output transfer on lane i occurs when out_valid[i] && out_ready[i]; on that edge full[i] SHALL clear unless the same edge loads lane i.
REQ-016 Simultaneous output transfer and input transfer on the same lane SHALL replace the data and keep full=1, with no bubble and no lost word.
REQ-017 Transfers on different lanes in the same cycle SHALL be independent; up to one input and four output transfers SHALL complete per cycle.
REQ-018 A full lane with out_ready low SHALL hold its data and full flag unchanged (no overwrite), and SHALL stall only inputs addressed to that lane.
REQ-019 When in_valid is 0, sel and in_data SHALL be don't-care and SHALL cause no state change.
REQ-020 out_valid[i] SHALL NOT depend combinationally on out_ready[i], and out_i SHALL be stable while out_valid[i]=1 and out_ready[i]=0.
REQ-021 pending SHALL be registered and always equal the population count of the full flags after the same edge.
REQ-022 Words SHALL be delivered per lane in acceptance order; the block SHALL NOT reorder, duplicate or drop words.

Reset
REQ-023 When rst=1 at a clock edge, all full flags SHALL clear, all lane data registers SHALL become 0, and pending SHALL become 0, regardless of in-flight transfers.
REQ-024 During and after reset, out_valid SHALL be 4'b0000, in_ready SHALL be 1 for every sel, and out_0..out_3 SHALL be 0.
REQ-025 An input offered in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-026 The bench SHALL cover basic routing: after reset, in_valid=1, sel=2, in_data=16'hA5A5 for one cycle with out_ready=0 -> next cycle out_valid=4'b0100, out_2=16'hA5A5, pending=1.
REQ-027 The bench SHALL cover backpressure: lane 1 full, out_ready=0, offer sel=1, 16'h1111 -> in_ready=0 and out_1 unchanged; offer sel=3, 16'h3333 -> in_ready=1 and out_valid=4'b1010, pending=2.
REQ-028 The bench SHALL cover pass-through: lane 0 full with 16'h0001, out_ready[0]=1, offer sel=0, 16'h0002 -> in_ready=1, next cycle out_0=16'h0002, out_valid[0]=1, pending=1.
REQ-029 The bench SHALL cover all lanes full: fill lanes 0-3 with out_ready=0 -> pending=4 and in_ready=0 for all sel; set out_ready=4'b1111 for one cycle -> pending=0, out_valid=0.
REQ-030 The bench SHALL cover mid-operation reset: lanes 0 and 3 full, pulse rst with in_valid=1, sel=1 -> next cycle out_valid=0, pending=0, out_0..out_3=0, and lane 1 not loaded.
REQ-031 The bench SHALL cover a random stream with random out_ready -> per-lane scoreboard shows in-order, lossless, duplicate-free delivery and pending consistent with out_valid every cycle.
